// File: rtl/rotate_amount_detector.sv
// Iterative inverse of the right-rotate datapath: finds the smallest k with
// rotr(b, k) == target, testing one candidate rotation per clock.
module rotate_amount_detector #(
    parameter int unsigned N   = 32,
    parameter int unsigned LVL = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           in_ready,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   target,
    output logic           done,
    output logic           found,
    output logic [LVL-1:0] amount,
    output logic [LVL-1:0] amount_left
);

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   cur;
    logic [N-1:0]   tgt;
    logic [LVL-1:0] cnt;
    logic           match;
    logic           last;

    assign match = (cur == tgt);
    assign last  = (cnt == LVL'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SEARCH;
            SEARCH:  if (match || last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    // The match test precedes the last-candidate test so a rotation of N-1 is still found.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= '0;
            tgt    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            found  <= 1'b0;
            amount <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur    <= b;
                        tgt    <= target;
                        cnt    <= '0;
                        found  <= 1'b0;
                        amount <= '0;
                    end
                end
                SEARCH: begin
                    if (match) begin
                        amount <= cnt;
                        found  <= 1'b1;
                        done   <= 1'b1;
                    end else if (last) begin
                        amount <= '0;
                        found  <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        cur <= {cur[0], cur[N-1:1]};
                        cnt <= cnt + LVL'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // N == 2**LVL, so negation in LVL bits is (N - amount) mod N.
    always_comb begin
        amount_left = found ? (-amount) : '0;
    end

endmodule
